// File: rtl/load_store_unit.sv
// Load/store unit: checks a CPU load/store request and serialises it into little-endian
// single-byte accesses to a byte-wide memory with a one-cycle registered read.
module load_store_unit #(
  parameter int unsigned MEM_ADDR_W = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    write_q;
  logic [2:0]              funct3_q;
  logic [MEM_ADDR_W-1:0]   base_q;
  logic [31:0]             wdata_q;
  logic [1:0]              idx_q;
  logic [31:0]             rdata_q;
  logic                    error_q;

  logic       accept, legal, f3_ok, aligned, in_range;
  logic [1:0] last_idx, cap_lane;
  logic       cap_en;
  logic [31:0] ext_data;

  assign accept = req_valid && (state_q == StIdle);

  // Byte-only codes need no alignment; unsigned variants exist only for loads.
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b0;
    case (req_funct3)
      3'b000: begin f3_ok = 1'b1;       aligned = 1'b1;                 end
      3'b001: begin f3_ok = 1'b1;       aligned = ~req_addr[0];         end
      3'b010: begin f3_ok = 1'b1;       aligned = (req_addr[1:0] == 2'b00); end
      3'b100: begin f3_ok = ~req_write; aligned = 1'b1;                 end
      3'b101: begin f3_ok = ~req_write; aligned = ~req_addr[0];         end
      default: ;
    endcase
  end

  assign in_range = ((req_addr >> MEM_ADDR_W) == 32'd0);
  assign legal    = f3_ok && aligned && in_range;

  assign last_idx = funct3_q[1] ? 2'd3 : (funct3_q[0] ? 2'd1 : 2'd0);

  // Read data lags its access by one cycle, so byte idx-1 lands while idx is issued.
  assign cap_en   = !write_q && (((state_q == StXfer) && (idx_q != 2'd0)) || (state_q == StDrain));
  assign cap_lane = (state_q == StDrain) ? last_idx : idx_q - 2'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = legal ? StXfer : StResp;
      StXfer:  if (idx_q == last_idx) state_d = write_q ? StResp : StDrain;
      StDrain: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      base_q   <= '0;
      wdata_q  <= 32'd0;
      idx_q    <= 2'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        base_q   <= req_addr[MEM_ADDR_W-1:0];
        wdata_q  <= req_wdata;
        idx_q    <= 2'd0;
        rdata_q  <= 32'd0;
        error_q  <= ~legal;
      end else begin
        if (state_q == StXfer) idx_q <= idx_q + 2'd1;
        if (cap_en) rdata_q[{cap_lane, 3'b000} +: 8] <= mem_rdata;
      end
    end
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext_data = {{24{rdata_q[7]}}, rdata_q[7:0]};
      3'b001:  ext_data = {{16{rdata_q[15]}}, rdata_q[15:0]};
      3'b100:  ext_data = {24'd0, rdata_q[7:0]};
      3'b101:  ext_data = {16'd0, rdata_q[15:0]};
      default: ext_data = rdata_q;
    endcase
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_error = resp_valid && error_q;
  assign resp_rdata = (resp_valid && !error_q && !write_q) ? ext_data : 32'd0;

  assign mem_en    = (state_q == StXfer);
  assign mem_we    = mem_en && write_q;
  assign mem_addr  = mem_en ? base_q + MEM_ADDR_W'(idx_q) : '0;
  assign mem_wdata = mem_en ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit against a 1 KiB byte memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:1023];

  logic       en_log   [0:20];
  logic       we_log   [0:20];
  logic [9:0] addr_log [0:20];
  logic [7:0] wd_log   [0:20];
  logic       rdy_log  [0:20];
  logic       rv_log   [0:20];

  int          rcyc;
  logic [31:0] rdata;
  logic        err;
  int          nen;

  load_store_unit #(.MEM_ADDR_W(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request in IDLE and watch up to 20 cycles for the response.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
    rcyc  = -1;
    nen   = 0;
    rdata = 32'hxxxx_xxxx;
    err   = 1'bx;
    for (int c = 1; c <= 20 && rcyc < 0; c++) begin
      @(negedge clock);
      en_log[c]   = mem_en;
      we_log[c]   = mem_we;
      addr_log[c] = mem_addr;
      wd_log[c]   = mem_wdata;
      if (mem_en) nen++;
      if (resp_valid) begin
        rcyc  = c;
        rdata = resp_rdata;
        err   = resp_error;
      end
    end
  endtask

  logic [7:0] sw_bytes [0:3];

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // 1. SW 0xDEADBEEF @8
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
    run_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_en%0d", i), 32'(en_log[i+1]), 32'd1);
      check($sformatf("sw_we%0d", i), 32'(we_log[i+1]), 32'd1);
      check($sformatf("sw_addr%0d", i), 32'(addr_log[i+1]), 32'(8 + i));
      check($sformatf("sw_wdata%0d", i), 32'(wd_log[i+1]), 32'(sw_bytes[i]));
    end
    check("sw_resp_cycle", 32'(rcyc), 32'd5);
    check("sw_error", 32'(err), 32'd0);
    check("sw_rdata", rdata, 32'd0);
    check("sw_mem11", 32'(mem[11]), 32'h0000_00DE);

    // 2. loads of the stored word
    run_req(1'b0, 3'b000, 32'd11, 32'd0);
    check("lb11", rdata, 32'hFFFF_FFDE);
    run_req(1'b0, 3'b100, 32'd11, 32'd0);
    check("lbu11", rdata, 32'h0000_00DE);
    run_req(1'b0, 3'b001, 32'd10, 32'd0);
    check("lh10", rdata, 32'hFFFF_DEAD);
    check("lh_resp_cycle", 32'(rcyc), 32'd4);
    run_req(1'b0, 3'b101, 32'd10, 32'd0);
    check("lhu10", rdata, 32'h0000_DEAD);
    run_req(1'b0, 3'b010, 32'd8, 32'd0);
    check("lw8", rdata, 32'hDEAD_BEEF);
    check("lw_resp_cycle", 32'(rcyc), 32'd6);
    check("lw_error", 32'(err), 32'd0);
    check("lw_we", 32'(we_log[1]), 32'd0);

    // 3. illegal requests
    run_req(1'b0, 3'b010, 32'd6, 32'd0);
    check("lw6_err", 32'(err), 32'd1);
    check("lw6_cycle", 32'(rcyc), 32'd1);
    check("lw6_nen", 32'(nen), 32'd0);
    check("lw6_rdata", rdata, 32'd0);
    run_req(1'b1, 3'b001, 32'd3, 32'h1234);
    check("sh3_err", 32'(err), 32'd1);
    check("sh3_cycle", 32'(rcyc), 32'd1);
    check("sh3_nen", 32'(nen), 32'd0);
    run_req(1'b0, 3'b011, 32'd0, 32'd0);
    check("ld011_err", 32'(err), 32'd1);
    check("ld011_nen", 32'(nen), 32'd0);
    run_req(1'b1, 3'b100, 32'd0, 32'd0);
    check("sw100_err", 32'(err), 32'd1);
    check("sw100_nen", 32'(nen), 32'd0);
    check("sw100_cycle", 32'(rcyc), 32'd1);

    // 4. range boundary
    run_req(1'b0, 3'b000, 32'd1024, 32'd0);
    check("lb1024_err", 32'(err), 32'd1);
    check("lb1024_nen", 32'(nen), 32'd0);
    run_req(1'b1, 3'b000, 32'd1023, 32'h0000_00A5);
    check("sb1023_err", 32'(err), 32'd0);
    run_req(1'b0, 3'b000, 32'd1023, 32'd0);
    check("lb1023_err", 32'(err), 32'd0);
    check("lb1023_nen", 32'(nen), 32'd1);
    check("lb1023_addr", 32'(addr_log[1]), 32'd1023);
    check("lb1023_rdata", rdata, 32'hFFFF_FFA5);
    check("lb1023_cycle", 32'(rcyc), 32'd3);

    // 5. back-to-back SB with req_valid held high
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'h0000_0011;
    @(posedge clock);
    #1;
    req_addr  = 32'd1;
    req_wdata = 32'h0000_0022;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      rdy_log[c]  = req_ready;
      en_log[c]   = mem_en;
      addr_log[c] = mem_addr;
      wd_log[c]   = mem_wdata;
      rv_log[c]   = resp_valid;
      if (c == 3) begin
        @(posedge clock);
        #1 req_valid = 1'b0;
      end
    end
    check("b2b_rdy1", 32'(rdy_log[1]), 32'd0);
    check("b2b_rdy2", 32'(rdy_log[2]), 32'd0);
    check("b2b_en1", 32'(en_log[1]), 32'd1);
    check("b2b_addr1", 32'(addr_log[1]), 32'd0);
    check("b2b_wd1", 32'(wd_log[1]), 32'h11);
    check("b2b_rv2", 32'(rv_log[2]), 32'd1);
    check("b2b_en2", 32'(en_log[2]), 32'd0);
    check("b2b_en3", 32'(en_log[3]), 32'd0);
    check("b2b_rdy3", 32'(rdy_log[3]), 32'd1);
    check("b2b_addr4", 32'(addr_log[4]), 32'd1);
    check("b2b_wd4", 32'(wd_log[4]), 32'h22);
    check("b2b_rv5", 32'(rv_log[5]), 32'd1);
    check("b2b_mem0", 32'(mem[0]), 32'h11);
    check("b2b_mem1", 32'(mem[1]), 32'h22);

    // 6. reset in the middle of SW @16
    run_req(1'b1, 3'b010, 32'd16, 32'd0);
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd16;
    req_wdata  = 32'h4433_2211;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_mem_en", 32'(mem_en), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_rel_ready", 32'(req_ready), 32'd1);
    check("rst_rel_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem16", 32'(mem[16]), 32'h11);
    check("rst_mem17", 32'(mem[17]), 32'h22);
    check("rst_mem18", 32'(mem[18]), 32'h00);
    check("rst_mem19", 32'(mem[19]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
